// File: rtl/midi_msg_encoder.sv
// MIDI channel-message transmitter: queues note events and serialises them as
// status/note/velocity bytes over a valid/ready byte stream, with optional running status.
module midi_msg_encoder #(
  parameter bit RUNNING_STATUS = 1'b1,
  parameter int RS_REFRESH     = 9_600_000,
  parameter int FIFO_AW        = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       note_pressed,
  input  logic       note_released,
  input  logic       note_keypress,
  input  logic [3:0] channel,
  input  logic [6:0] note,
  input  logic [6:0] velocity,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       fifo_full,
  output logic       drop,
  output logic       idle
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(RS_REFRESH + 1);

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] ch;
    logic [6:0] note;
    logic [6:0] vel;
  } evt_t;

  typedef enum logic [1:0] {S_IDLE, S_STATUS, S_DATA1, S_DATA2} state_t;

  evt_t               mem [DEPTH];
  logic [FIFO_AW-1:0] wp, rp;
  logic [FIFO_AW:0]   cnt;
  logic               empty, any_stb, collide, push, pop, hs, rs_hit;
  evt_t               wr_evt, head, msg;
  logic [7:0]         head_st, last_st, byte_n;
  logic               last_vld, valid_n;
  logic [TW-1:0]      rs_tmr;
  state_t             state, state_n;

  assign empty     = (cnt == '0);
  assign fifo_full = (cnt == (FIFO_AW+1)'(DEPTH));
  assign idle      = empty && (state == S_IDLE);
  assign any_stb   = note_pressed | note_released | note_keypress;
  assign collide   = (note_pressed & (note_released | note_keypress)) | (note_released & note_keypress);
  assign push      = any_stb && !fifo_full;
  assign hs        = byte_valid && byte_ready;
  assign head      = mem[rp];
  assign head_st   = {head.op, head.ch};
  assign rs_hit    = RUNNING_STATUS && last_vld && (last_st == head_st);

  always_comb begin
    wr_evt.op   = note_pressed ? 4'h9 : (note_released ? 4'h8 : 4'hA);
    wr_evt.ch   = channel;
    wr_evt.note = note;
    wr_evt.vel  = velocity;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wr_evt;
  end

  // A full FIFO refuses the write even if a pop frees a slot on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp   <= '0;
      rp   <= '0;
      cnt  <= '0;
      drop <= 1'b0;
    end else begin
      drop <= collide || (any_stb && fifo_full);
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    byte_n  = byte_data;
    valid_n = byte_valid;
    pop     = 1'b0;
    case (state)
      S_IDLE:   if (!empty) pop = 1'b1;
      S_STATUS: if (hs) begin
        state_n = S_DATA1;
        byte_n  = {1'b0, msg.note};
      end
      S_DATA1:  if (hs) begin
        state_n = S_DATA2;
        byte_n  = {1'b0, msg.vel};
      end
      S_DATA2:  if (hs) begin
        if (!empty) pop = 1'b1;
        else begin
          state_n = S_IDLE;
          valid_n = 1'b0;
        end
      end
      default:  state_n = S_IDLE;
    endcase
    // Popping covers both the idle start and back-to-back continuation from S_DATA2.
    if (pop) begin
      state_n = rs_hit ? S_DATA1 : S_STATUS;
      byte_n  = rs_hit ? {1'b0, head.note} : head_st;
      valid_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      byte_data  <= 8'h00;
      byte_valid <= 1'b0;
      msg        <= '0;
    end else begin
      state      <= state_n;
      byte_data  <= byte_n;
      byte_valid <= valid_n;
      if (pop) msg <= head;
    end
  end

  // Running status expires after RS_REFRESH idle cycles so a late-joining receiver resyncs.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_st  <= 8'h00;
      last_vld <= 1'b0;
      rs_tmr   <= '0;
    end else begin
      if (hs) rs_tmr <= '0;
      else if (state == S_IDLE && rs_tmr != TW'(RS_REFRESH)) rs_tmr <= rs_tmr + 1'b1;
      if (RUNNING_STATUS && state == S_STATUS && hs) begin
        last_st  <= {msg.op, msg.ch};
        last_vld <= 1'b1;
      end else if (rs_tmr == TW'(RS_REFRESH)) begin
        last_vld <= 1'b0;
      end
    end
  end

endmodule
